// File: rtl/ctrl_unit_seq.sv
// ctrl_unit_seq: registered decode/control stage between ID and ID/EXE.
// Decodes mode/op_code/s_in into execute and memory control. A memory
// instruction is held in MEM_WAIT until the data memory acknowledges it,
// or is dropped after MEM_TIMEOUT cycles with a one-cycle mem_err pulse.
//
// Ports:
//   clk, rst         clock, asynchronous active-low reset
//   in_valid         decode inputs carry a real instruction
//   mode, op_code    instruction class / data-processing opcode
//   s_in             S bit (load/store select in mode 01)
//   stall, flush     hazard freeze / branch-taken discard
//   mem_ready        data memory completes the current access
//   in_ready         instruction accepted this cycle if in_valid (combinational)
//   out_valid, exe_cmd, mem_r_en, mem_w_en, wb_en, s, b, undef
//                    registered control fields
//   mem_err          one-cycle pulse on memory timeout
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | no memory access outstanding; accept/bubble/hold each cycle
// MEM_WAIT | memory access issued, holding outputs until mem_ready or timeout
module ctrl_unit_seq #(
  parameter  int MEM_TIMEOUT = 15,
  localparam int CNT_W       = $clog2(MEM_TIMEOUT + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [1:0] mode,
  input  logic [3:0] op_code,
  input  logic       s_in,
  input  logic       stall,
  input  logic       flush,
  input  logic       mem_ready,
  output logic       in_ready,
  output logic       out_valid,
  output logic [3:0] exe_cmd,
  output logic       mem_r_en,
  output logic       mem_w_en,
  output logic       wb_en,
  output logic       s,
  output logic       b,
  output logic       undef,
  output logic       mem_err
);

  typedef enum logic {IDLE, MEM_WAIT} state_t;

  typedef struct packed {
    logic       out_valid;
    logic [3:0] exe_cmd;
    logic       mem_r_en;
    logic       mem_w_en;
    logic       wb_en;
    logic       s;
    logic       b;
    logic       undef;
  } ctrl_t;

  state_t           state_q, state_nxt;
  ctrl_t            ctrl_q, ctrl_nxt, dec;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic             mem_err_q, mem_err_nxt;
  logic             slot_open;

  always_comb begin
    dec = '0;
    dec.out_valid = 1'b1;
    case (mode)
      2'b00: begin
        dec.wb_en = 1'b1;
        dec.s     = s_in;
        case (op_code)
          4'b1101: dec.exe_cmd = 4'b0001;
          4'b1111: dec.exe_cmd = 4'b1001;
          4'b0100: dec.exe_cmd = 4'b0010;
          4'b0101: dec.exe_cmd = 4'b0011;
          4'b0010: dec.exe_cmd = 4'b0100;
          4'b0110: dec.exe_cmd = 4'b0101;
          4'b0000: dec.exe_cmd = 4'b0110;
          4'b1100: dec.exe_cmd = 4'b0111;
          4'b0001: dec.exe_cmd = 4'b1000;
          4'b1010: begin
            dec.exe_cmd = 4'b0100;
            dec.wb_en   = 1'b0;
          end
          4'b1000: begin
            dec.exe_cmd = 4'b0110;
            dec.wb_en   = 1'b0;
          end
          default: begin
            dec           = '0;
            dec.out_valid = 1'b1;
            dec.undef     = 1'b1;
          end
        endcase
      end
      2'b01: begin
        dec.exe_cmd = 4'b0010;
        if (s_in) begin
          dec.mem_r_en = 1'b1;
          dec.wb_en    = 1'b1;
        end else begin
          dec.mem_w_en = 1'b1;
        end
      end
      2'b10: begin
        dec.b = 1'b1;
        dec.s = s_in;
      end
      default: dec.undef = 1'b1;
    endcase
  end

  // The issue slot is open in IDLE, and in MEM_WAIT on the cycle the
  // outstanding access completes.
  assign slot_open = (state_q == IDLE) || mem_ready;
  assign in_ready  = (state_q == IDLE) ? ~stall : (mem_ready & ~stall);

  always_comb begin
    state_nxt   = state_q;
    ctrl_nxt    = ctrl_q;
    cnt_nxt     = cnt_q;
    mem_err_nxt = 1'b0;
    if (slot_open) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      if (flush) begin
        ctrl_nxt = '0;
      end else if (stall) begin
        // A completed access must not stay enabled, so a stall on the
        // completion cycle bubbles instead of holding.
        if (state_q == MEM_WAIT) ctrl_nxt = '0;
      end else if (in_valid) begin
        ctrl_nxt = dec;
        if (mode == 2'b01) state_nxt = MEM_WAIT;
      end else begin
        ctrl_nxt = '0;
      end
    end else if (cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
      ctrl_nxt    = '0;
      mem_err_nxt = 1'b1;
      state_nxt   = IDLE;
      cnt_nxt     = '0;
    end else begin
      cnt_nxt = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      ctrl_q    <= '0;
      cnt_q     <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      ctrl_q    <= ctrl_nxt;
      cnt_q     <= cnt_nxt;
      mem_err_q <= mem_err_nxt;
    end
  end

  assign out_valid = ctrl_q.out_valid;
  assign exe_cmd   = ctrl_q.exe_cmd;
  assign mem_r_en  = ctrl_q.mem_r_en;
  assign mem_w_en  = ctrl_q.mem_w_en;
  assign wb_en     = ctrl_q.wb_en;
  assign s         = ctrl_q.s;
  assign b         = ctrl_q.b;
  assign undef     = ctrl_q.undef;
  assign mem_err   = mem_err_q;

endmodule

// File: tb/tb_ctrl_unit_seq.sv
// Directed bench for ctrl_unit_seq with MEM_TIMEOUT=4.
// Output vector layout: {out_valid, exe_cmd[3:0], mem_r_en, mem_w_en,
// wb_en, s, b, undef, mem_err}.
module tb_ctrl_unit_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [1:0] mode;
  logic [3:0] op_code;
  logic       s_in;
  logic       stall;
  logic       flush;
  logic       mem_ready;
  logic       in_ready;
  logic       out_valid;
  logic [3:0] exe_cmd;
  logic       mem_r_en;
  logic       mem_w_en;
  logic       wb_en;
  logic       s;
  logic       b;
  logic       undef;
  logic       mem_err;

  int checks = 0;
  int errors = 0;

  ctrl_unit_seq #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .mode(mode), .op_code(op_code),
    .s_in(s_in), .stall(stall), .flush(flush), .mem_ready(mem_ready),
    .in_ready(in_ready), .out_valid(out_valid), .exe_cmd(exe_cmd),
    .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .wb_en(wb_en), .s(s), .b(b),
    .undef(undef), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        iv;
    logic [1:0]  md;
    logic [3:0]  op;
    logic        si;
    logic        st;
    logic        fl;
    logic        mr;
    logic        rdy;
    logic [11:0] exp;
  } vec_t;

  vec_t vq[$];

  // Common expected vectors
  localparam logic [11:0] BUBBLE = 12'b0_0000_0_0_0_0_0_0_0;
  localparam logic [11:0] MOV    = 12'b1_0001_0_0_1_0_0_0_0;
  localparam logic [11:0] UND    = 12'b1_0000_0_0_0_0_0_1_0;
  localparam logic [11:0] LDR    = 12'b1_0010_1_0_1_0_0_0_0;
  localparam logic [11:0] STR    = 12'b1_0010_0_1_0_0_0_0_0;
  localparam logic [11:0] ADD1   = 12'b1_0010_0_0_1_1_0_0_0;
  localparam logic [11:0] ERR    = 12'b0_0000_0_0_0_0_0_0_1;

  function automatic logic [11:0] outs();
    return {out_valid, exe_cmd, mem_r_en, mem_w_en, wb_en, s, b, undef, mem_err};
  endfunction

  task automatic check_out(input string name, input logic [11:0] exp);
    checks++;
    if (outs() !== exp) begin
      errors++;
      $display("FAIL %s outputs got %b expected %b", name, outs(), exp);
    end
  endtask

  task automatic check_rdy(input string name, input logic exp);
    checks++;
    if (in_ready !== exp) begin
      errors++;
      $display("FAIL %s in_ready got %b expected %b", name, in_ready, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [1:0] md, input logic [3:0] op,
                       input logic si, input logic st, input logic fl, input logic mr);
    in_valid = iv; mode = md; op_code = op; s_in = si;
    stall = st; flush = fl; mem_ready = mr;
  endtask

  // Inputs are already applied; check in_ready, clock once, check outputs.
  task automatic step(input string name, input logic rdy, input logic [11:0] exp);
    #1;
    check_rdy(name, rdy);
    @(posedge clk);
    #1;
    check_out(name, exp);
  endtask

  initial begin
    //              iv  md     op       si    st    fl    mr    rdy   expected
    vq.push_back('{1'b1, 2'b00, 4'b1101, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, MOV});
    vq.push_back('{1'b1, 2'b00, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 12'b1_1001_0_0_1_1_0_0_0});
    vq.push_back('{1'b1, 2'b00, 4'b0100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, ADD1});
    vq.push_back('{1'b1, 2'b00, 4'b1010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 12'b1_0100_0_0_0_1_0_0_0});
    vq.push_back('{1'b1, 2'b00, 4'b0101, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'b1_0011_0_0_1_0_0_0_0});
    vq.push_back('{1'b1, 2'b00, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'b1_0100_0_0_1_0_0_0_0});
    vq.push_back('{1'b1, 2'b00, 4'b0110, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 12'b1_0101_0_0_1_1_0_0_0});
    vq.push_back('{1'b1, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'b1_0110_0_0_1_0_0_0_0});
    vq.push_back('{1'b1, 2'b00, 4'b1100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'b1_0111_0_0_1_0_0_0_0});
    vq.push_back('{1'b1, 2'b00, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 12'b1_1000_0_0_1_1_0_0_0});
    vq.push_back('{1'b1, 2'b00, 4'b1000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 12'b1_0110_0_0_0_1_0_0_0});
    vq.push_back('{1'b1, 2'b10, 4'b0011, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 12'b1_0000_0_0_0_1_1_0_0});
    vq.push_back('{1'b1, 2'b11, 4'b0101, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, UND});
    vq.push_back('{1'b1, 2'b00, 4'b0011, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, UND});
    vq.push_back('{1'b1, 2'b00, 4'b1110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, UND});
    vq.push_back('{1'b1, 2'b00, 4'b1001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, UND});
    vq.push_back('{1'b0, 2'b00, 4'b1101, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, BUBBLE});
    vq.push_back('{1'b1, 2'b00, 4'b1101, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, MOV});
    vq.push_back('{1'b1, 2'b00, 4'b0100, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, MOV});
    vq.push_back('{1'b1, 2'b00, 4'b0100, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, MOV});
    vq.push_back('{1'b0, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, BUBBLE});
    vq.push_back('{1'b1, 2'b10, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, BUBBLE});
    vq.push_back('{1'b1, 2'b00, 4'b1101, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, MOV});
    vq.push_back('{1'b1, 2'b00, 4'b0100, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, BUBBLE});
    vq.push_back('{1'b1, 2'b01, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, BUBBLE});
    vq.push_back('{1'b1, 2'b00, 4'b0100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, ADD1});
    vq.push_back('{1'b1, 2'b11, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, UND});
    vq.push_back('{1'b1, 2'b00, 4'b1101, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, UND});
    vq.push_back('{1'b0, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, BUBBLE});

    // Reset state
    rst = 1'b0;
    drive(1'b0, 2'b00, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
    #2;
    check_out("reset_outputs", BUBBLE);
    check_rdy("reset_rdy_stall", 1'b0);
    stall = 1'b0;
    #1;
    check_rdy("reset_rdy_nostall", 1'b1);
    @(posedge clk);
    #1;
    check_out("reset_held", BUBBLE);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Table-driven decode, stall, flush vectors
    foreach (vq[i]) begin
      drive(vq[i].iv, vq[i].md, vq[i].op, vq[i].si, vq[i].st, vq[i].fl, vq[i].mr);
      step($sformatf("vec%0d", i), vq[i].rdy, vq[i].exp);
    end

    // LDR held 4 cycles, STR waiting, accepted on mem_ready cycle
    drive(1'b1, 2'b01, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
    step("ldr_accept", 1'b1, LDR);
    drive(1'b1, 2'b01, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) step($sformatf("ldr_wait%0d", k), 1'b0, LDR);
    mem_ready = 1'b1;
    step("str_after_ldr", 1'b1, STR);
    // Back-to-back with mem_ready held high
    drive(1'b1, 2'b01, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1);
    step("ldr_b2b", 1'b1, LDR);
    drive(1'b0, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
    step("b2b_done", 1'b1, BUBBLE);

    // STR timeout; flush inside MEM_WAIT is ignored
    drive(1'b1, 2'b01, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    step("str_accept", 1'b1, STR);
    drive(1'b0, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    step("str_wait0", 1'b0, STR);
    flush = 1'b1;
    step("str_wait1_flush", 1'b0, STR);
    flush = 1'b0;
    step("str_wait2", 1'b0, STR);
    step("str_timeout", 1'b0, ERR);
    step("after_timeout", 1'b1, BUBBLE);

    // Async reset mid-MEM_WAIT
    drive(1'b1, 2'b01, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
    step("rst_ldr_accept", 1'b1, LDR);
    drive(1'b0, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    step("rst_ldr_wait", 1'b0, LDR);
    rst = 1'b0;
    #1;
    check_out("async_reset", BUBBLE);
    drive(1'b1, 2'b00, 4'b0100, 1'b1, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    step("post_reset_add", 1'b1, ADD1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
